bch_serial_encoder: RTL and testbench
=====================================

Name: bch_serial_encoder

Overview:
- Systematic serial BCH encoder; the transmit end of the BCH link whose decoder is exercised by the sim bench.
- Accepts one K-bit message word per handshake and emits an N-bit codeword serially, one bit per accepted output beat.
- Data bits go out MSB first, followed by N-K parity bits computed by an LFSR divider over the generator polynomial.
- Sits between the message source and the error-injection channel / decoder.

Parameters:
- N, 31, codeword length in bits.
- K, 11, message length in bits; N-K is the parity width, 20 at default.
- GPOLY, 21'h1626D5 (octal 5423325), generator polynomial g(x), N-K+1 bits wide, bit i = coefficient of x^i, bit N-K must be 1.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- din  input  K  message word; din[K-1] is the coefficient of x^(N-1) in the codeword.
- din_valid  input  1  din is valid.
- din_ready  output  1  encoder can accept a word; high only in IDLE.
- dout  output  1  current codeword bit.
- dout_valid  output  1  dout is valid.
- dout_ready  input  1  downstream accepts dout this cycle.
- dout_first  output  1  qualifies the first bit of the codeword (the din[K-1] bit).
- dout_last  output  1  qualifies the final parity bit (x^0).

Behaviour:
- Reset values: state=IDLE, din_ready=1, dout=0, dout_valid=0, dout_first=0, dout_last=0; LFSR, data shift register and bit counter cleared.
- Beat: a cycle in which dout_valid and dout_ready are both high. Load: a cycle in which din_valid and din_ready are both high.
- IDLE:
  - On load, capture din into the data shift register, clear the LFSR, clear the counter and go to DATA.
  - dout_valid rises the next cycle, giving one cycle of latency from load to the first bit.
  - din is ignored while din_ready is low.
- DATA:
  - dout = data_sr[K-1]; dout_valid=1.
  - On a beat: fb = dout ^ lfsr[N-K-1]; lfsr <= (lfsr<<1) ^ (fb ? GPOLY[N-K-1:0] : 0); data_sr <= data_sr<<1; count increments.
  - After beat K-1 (the K-th bit), go to PARITY.
- PARITY:
  - dout = lfsr[N-K-1].
  - On a beat: lfsr <= lfsr<<1 with zero fill; count increments.
  - After beat N-1, go to IDLE; din_ready returns high the following cycle.
  - There is one idle cycle between codewords; no back-to-back overlap.
- Stall: while dout_ready=0, dout, dout_first, dout_last, the LFSR and the counter all hold. dout must remain stable whenever dout_valid=1 and no beat occurs.
- dout_first = (state==DATA && count==0). dout_last = (state==PARITY && count==N-1).
- Counter width is $clog2(N); it never wraps within a codeword.
- Output is combinational from registered state only; there is no combinational path from din or dout_ready to any output.
- Reset mid-codeword (asynchronous):
  - Outputs drop to their reset values immediately and the partial codeword is abandoned.
  - The next load after release starts a fresh codeword.
- din_valid asserted while not in IDLE: no effect; the source holds the word until din_ready.

Test Plan:
- din=11'h000, dout_ready=1 constantly -> 31 beats all 0; dout_first on beat 0, dout_last on beat 30; din_ready high one cycle after beat 30.
- din=11'h001 -> serial stream equals 31'h001626D5 MSB first (the codeword is g(x) itself).
- 100 random din with random dout_ready stalls (~30% low) -> each collected codeword is divisible by g(x) (bench polynomial remainder = 0), and bits 30..20 equal din. The bit sequence must be identical to the no-stall run with the same seed.
- Linearity: encode a=11'h5A3 and b=11'h2C6 -> codeword(a) XOR codeword(b) equals codeword(11'h765).
- Assert reset at beat 15 of a codeword, release after 2 cycles -> dout_valid=0 and din_ready=1 immediately; the next word din=11'h001 encodes to 31'h001626D5 with no residue from the aborted word.
- Closed loop: connect to the sim decoder through the tb error injector with 0..T=5 random flips for 100 iterations -> decoded word equals din and wrong never asserts.

Source files
------------

// File: rtl/bch_serial_encoder.sv
// Systematic serial BCH encoder: takes one K-bit message per handshake and
// emits the N-bit codeword serially, data MSB first, then LFSR parity bits.
module bch_serial_encoder #(
    parameter int unsigned N = 31,
    parameter int unsigned K = 11,
    parameter logic [N-K:0] GPOLY = 21'h1626D5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [K-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    output logic         dout,
    output logic         dout_valid,
    input  logic         dout_ready,
    output logic         dout_first,
    output logic         dout_last
);

    localparam int unsigned P  = N - K;
    localparam int unsigned CW = $clog2(N);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [K-1:0]  data_sr;
    logic [P-1:0]  lfsr;
    logic [CW-1:0] count;
    logic          fb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (din_valid) next_state = DATA;
            end
            DATA: begin
                if (dout_ready && count == CW'(K - 1)) next_state = PARITY;
            end
            PARITY: begin
                if (dout_ready && count == CW'(N - 1)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Division feedback: outgoing message bit folded into the remainder MSB
    assign fb = data_sr[K-1] ^ lfsr[P-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sr <= '0;
            lfsr    <= '0;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_valid) begin
                        data_sr <= din;
                        lfsr    <= '0;
                        count   <= '0;
                    end
                end
                DATA: begin
                    if (dout_ready) begin
                        lfsr    <= {lfsr[P-2:0], 1'b0} ^ (fb ? GPOLY[P-1:0] : P'(0));
                        data_sr <= {data_sr[K-2:0], 1'b0};
                        count   <= count + CW'(1);
                    end
                end
                PARITY: begin
                    if (dout_ready) begin
                        lfsr  <= {lfsr[P-2:0], 1'b0};
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    data_sr <= data_sr;
                end
            endcase
        end
    end

    // Outputs decode registered state only; nothing combinational from inputs
    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == DATA) || (state == PARITY);
    assign dout       = (state == DATA)   ? data_sr[K-1] :
                        (state == PARITY) ? lfsr[P-1]    : 1'b0;
    assign dout_first = (state == DATA) && (count == '0);
    assign dout_last  = (state == PARITY) && (count == CW'(N - 1));

endmodule

// File: tb/tb_bch_serial_encoder.sv
// Self-checking bench for bch_serial_encoder: a long-division reference model
// fills an expected-codeword queue; a beat monitor collects serial codewords.
module tb_bch_serial_encoder;

    localparam int unsigned N = 31;
    localparam int unsigned K = 11;
    localparam logic [20:0] GPOLY_TB = 21'h1626D5;

    logic        clk;
    logic        reset;
    logic [10:0] din;
    logic        din_valid;
    logic        din_ready;
    logic        dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        dout_first;
    logic        dout_last;

    int checks   = 0;
    int failures = 0;
    int stall_pct = 0;

    logic [30:0] exp_q[$];
    logic [30:0] obs_q[$];

    int          mon_pos = 0;
    logic [30:0] mon_cw  = '0;
    logic        prev_stall = 1'b0;
    logic        prev_dout  = 1'b0;

    bch_serial_encoder #(.N(31), .K(11), .GPOLY(21'h1626D5)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_first (dout_first),
        .dout_last  (dout_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [30:0] model_cw(input logic [10:0] m);
        logic [30:0] r;
        r = {m, 20'b0};
        for (int i = 30; i >= 20; i--)
            if (r[i]) r = r ^ (31'(GPOLY_TB) << (i - 20));
        return {m, r[19:0]};
    endfunction

    function automatic logic [19:0] mod_g(input logic [30:0] cw);
        logic [30:0] r;
        r = cw;
        for (int i = 30; i >= 20; i--)
            if (r[i]) r = r ^ (31'(GPOLY_TB) << (i - 20));
        return r[19:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Random backpressure, refreshed just after every rising edge
    initial begin
        dout_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dout_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
        end
    end

    // Beat monitor: flags, stall stability, codeword assembly
    always @(negedge clk) begin
        if (reset) begin
            mon_pos    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && dout_valid) check("stall_hold", 32'(dout), 32'(prev_dout));
            prev_stall = dout_valid && !dout_ready;
            prev_dout  = dout;
            if (dout_valid && dout_ready) begin
                check("first_flag", 32'(dout_first), 32'(mon_pos == 0));
                check("last_flag", 32'(dout_last), 32'(mon_pos == N - 1));
                mon_cw = {mon_cw[29:0], dout};
                if (mon_pos == N - 1) begin
                    obs_q.push_back(mon_cw);
                    mon_pos = 0;
                end else begin
                    mon_pos++;
                end
            end
        end
    end

    task automatic send(input logic [10:0] w);
        int budget;
        bit ok;
        budget    = 0;
        ok        = 1'b0;
        din       = w;
        din_valid = 1'b1;
        while (!ok && budget < 200) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        din_valid = 1'b0;
        if (!ok) begin
            check("load_timeout", 32'd0, 32'd1);
        end else begin
            exp_q.push_back(model_cw(w));
            check("busy_after_load", 32'(din_ready), 32'd0);
        end
    endtask

    task automatic receive(input string tag, output logic [30:0] got);
        int budget;
        budget = 0;
        got    = '0;
        while (obs_q.size() == 0 && budget < 400) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            got = obs_q.pop_front();
            check(tag, 32'(got), 32'(exp_q.pop_front()));
            check({tag, "_rem"}, 32'(mod_g(got)), 32'd0);
        end
    endtask

    initial begin
        logic [30:0] got;
        logic [30:0] cw_a;
        logic [30:0] cw_b;
        logic [30:0] cw_ab;
        logic [10:0] w;
        int          budget;

        reset     = 1'b1;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_first", 32'(dout_first), 32'd0);
        check("rst_last", 32'(dout_last), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All-zero message, no stalls
        send(11'h000);
        receive("zero_word", got);
        check("zero_const", 32'(got), 32'd0);
        check("ready_after_last", 32'(din_ready), 32'd1);
        check("idle_valid_low", 32'(dout_valid), 32'd0);

        // Unit message gives g(x) itself
        send(11'h001);
        receive("unit_word", got);
        check("unit_const", 32'(got), 32'h001626D5);

        // din changes while busy must not disturb the codeword
        send(11'h0F0);
        din       = 11'h3FF;
        din_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        din_valid = 1'b0;
        receive("busy_ignore", got);

        // Linearity
        send(11'h5A3);
        receive("lin_a", cw_a);
        send(11'h2C6);
        receive("lin_b", cw_b);
        send(11'h765);
        receive("lin_ab", cw_ab);
        check("linearity", 32'(cw_a ^ cw_b), 32'(cw_ab));

        // Random words under ~30% backpressure
        stall_pct = 30;
        for (int i = 0; i < 100; i++) begin
            w = 11'($urandom);
            send(w);
            receive("rand_word", got);
            check("rand_msg_bits", 32'(got[30:20]), 32'(w));
        end
        stall_pct = 0;
        repeat (2) @(posedge clk);
        #1;

        // Asynchronous reset mid-codeword
        send(11'h7FF);
        budget = 0;
        while (mon_pos != 15 && budget < 100) begin
            @(negedge clk);
            #1;
            budget++;
        end
        check("reach_beat15", 32'(mon_pos), 32'd15);
        reset = 1'b1;
        #1;
        check("abort_valid", 32'(dout_valid), 32'd0);
        check("abort_ready", 32'(din_ready), 32'd1);
        check("abort_dout", 32'(dout), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        check("abort_no_obs", 32'(obs_q.size()), 32'd0);
        send(11'h001);
        receive("after_reset", got);
        check("after_reset_const", 32'(got), 32'h001626D5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
